// File: rtl/if_id_register.sv
// if_id_register: fetch-to-decode pipeline register for the five-stage MIPS core.
// Latches the fetched word and its PC for decode, owns the multi-cycle freeze
// countdown shared with the program counter, squashes the fetched word on a
// taken branch/jump, and counts valid instructions delivered to decode.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   if_pc          PC of the word being fetched this cycle
//   if_instr       instruction memory read data for if_pc (same cycle)
//   stall_request  cycles to freeze fetch (0 = no stall), from the hazard unit
//   flush          taken branch/jump resolved this cycle
//   freeze         to the program counter; nonzero = hold PC (combinational)
//   id_valid       id_instr is a real instruction, not a bubble
//   id_pc          PC of the latched instruction
//   id_instr       latched instruction word
//   id_pc_plus4    id_pc + 4, registered
//   fetch_count    valid instructions latched since reset (wraps)
module if_id_register #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            if_instr,
  input  logic [COUNT_WIDTH-1:0] stall_request,
  input  logic                   flush,
  output logic [COUNT_WIDTH-1:0] freeze,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc_plus4,
  output logic [31:0]            fetch_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [31:0]            PC_STEP  = 32'd4;

  // freeze_cnt holds the number of hold edges still owed AFTER the current
  // one. A request of N therefore loads N-1, so a one-cycle stall never
  // leaves the counter nonzero.
  logic [COUNT_WIDTH-1:0] freeze_cnt;
  logic                   freeze_active;
  logic                   new_request;
  logic                   hold;
  logic [31:0]            if_pc_plus4;

  assign freeze_active = (freeze_cnt != CNT_ZERO);
  // A fresh request is only honoured when no freeze is in progress; requests
  // arriving mid-freeze are dropped rather than accumulated.
  assign new_request   = !freeze_active && (stall_request != CNT_ZERO);
  assign hold          = freeze_active || new_request;

  // The program counter must see the hold in the same cycle the hazard unit
  // raises it, so freeze bypasses the counter when it is idle.
  assign freeze = freeze_active ? freeze_cnt : stall_request;

  assign if_pc_plus4 = if_pc + PC_STEP;

  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_pc       <= RESET_PC;
      id_instr    <= NOP_WORD;
      id_pc_plus4 <= RESET_PC + PC_STEP;
      freeze_cnt  <= CNT_ZERO;
      fetch_count <= 32'd0;
    end else if (flush) begin
      // Bubble carries the fetch PC so decode still sees a coherent PC.
      // Any pending or newly requested freeze is cancelled.
      id_valid    <= 1'b0;
      id_pc       <= if_pc;
      id_instr    <= NOP_WORD;
      id_pc_plus4 <= if_pc_plus4;
      freeze_cnt  <= CNT_ZERO;
    end else if (hold) begin
      if (freeze_active) begin
        freeze_cnt <= freeze_cnt - CNT_ONE;
      end else begin
        freeze_cnt <= stall_request - CNT_ONE;
      end
    end else begin
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_instr    <= if_instr;
      id_pc_plus4 <= if_pc_plus4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_id_register.sv
// Testbench for if_id_register: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the stage.
module tb_if_id_register;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic [31:0] if_instr = 32'd0;
  logic [2:0]  stall_request = 3'd0;
  logic        flush = 1'b0;
  logic [2:0]  freeze;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [31:0] fetch_count;

  if_id_register #(
    .RESET_PC   (32'h0000_3000),
    .NOP_WORD   (32'h0000_0000),
    .COUNT_WIDTH(3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .stall_request(stall_request),
    .flush        (flush),
    .freeze       (freeze),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .fetch_count  (fetch_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: outputs seen by decode, plus how many more hold edges are owed.
  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_p4, m_cnt;
  int          m_left;
  bit          m_init = 0;
  logic [2:0]  last_freeze;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational freeze, let the edge
  // happen, advance the model, then check every registered output.
  task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [2:0] sr, input logic fl);
    logic [2:0] exp_fz;
    @(negedge clock);
    reset = r; if_pc = pc; if_instr = ins; stall_request = sr; flush = fl;
    #1;
    exp_fz = (m_left > 0) ? 3'(m_left) : sr;
    last_freeze = freeze;
    if (m_init) chk("freeze", 32'(freeze), 32'(exp_fz));
    @(posedge clock);
    if (r) begin
      m_valid = 0; m_pc = 32'h3000; m_instr = 0; m_p4 = 32'h3004; m_cnt = 0;
      m_left = 0; m_init = 1;
    end else if (fl) begin
      m_valid = 0; m_pc = pc; m_instr = 0; m_p4 = pc + 32'd4; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (sr != 0) begin
      m_left = int'(sr) - 1;
    end else begin
      m_valid = 1; m_pc = pc; m_instr = ins; m_p4 = pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    #1;
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_pc", id_pc, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc_plus4", id_pc_plus4, m_p4);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic load(input logic [31:0] pc);
    step(0, pc, $urandom, 3'd0, 0);
  endtask

  initial begin
    int nz;
    logic [31:0] pc;
    logic [31:0] cnt_before;

    // Reset and free-run.
    step(1, 32'h0, 32'h0, 3'd0, 0);
    chk("rst_pc_lit", id_pc, 32'h0000_3000);
    chk("rst_valid_lit", 32'(id_valid), 32'd0);
    chk("rst_p4_lit", id_pc_plus4, 32'h0000_3004);
    load(32'h3000);
    chk("ld1_pc_lit", id_pc, 32'h3000);
    chk("ld1_p4_lit", id_pc_plus4, 32'h3004);
    chk("ld1_cnt_lit", fetch_count, 32'd1);
    load(32'h3004);
    chk("ld2_p4_lit", id_pc_plus4, 32'h3008);
    chk("ld2_cnt_lit", fetch_count, 32'd2);

    // Three-cycle stall: freeze nonzero for exactly three cycles.
    nz = 0;
    step(0, 32'h3008, 32'hAAAA_0001, 3'd3, 0);
    if (last_freeze != 0) nz++;
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h3008, 32'hAAAA_0001, 3'd0, 0);
      if (last_freeze != 0) nz++;
    end
    chk("stall3_cycles_lit", 32'(nz), 32'd3);
    chk("stall3_pc_lit", id_pc, 32'h3008);
    chk("stall3_cnt_lit", fetch_count, 32'd3);

    // Request arriving while freeze_cnt=1 is ignored.
    step(0, 32'h300C, 32'h1, 3'd2, 0);
    step(0, 32'h300C, 32'h1, 3'd2, 0);
    step(0, 32'h300C, 32'h1, 3'd0, 0);
    chk("noext_valid_lit", 32'(id_valid), 32'd1);
    chk("noext_cnt_lit", fetch_count, 32'd4);

    // Flush together with a stall request.
    step(0, 32'h3010, 32'h2, 3'd4, 1);
    chk("flush_instr_lit", id_instr, 32'd0);
    chk("flush_cnt_lit", fetch_count, 32'd4);
    step(0, 32'h3014, 32'h3, 3'd0, 0);
    chk("flush_fz_lit", 32'(last_freeze), 32'd0);

    // Flush in the last freeze cycle.
    step(0, 32'h3018, 32'h4, 3'd2, 0);
    step(0, 32'h3018, 32'h4, 3'd0, 1);
    chk("flush_last_valid_lit", 32'(id_valid), 32'd0);

    // Reset mid-freeze.
    step(0, 32'h301C, 32'h5, 3'd3, 0);
    step(1, 32'h301C, 32'h5, 3'd0, 0);
    chk("rst_mid_pc_lit", id_pc, 32'h3000);
    step(0, 32'h301C, 32'h5, 3'd0, 0);
    chk("rst_mid_fz_lit", 32'(last_freeze), 32'd0);

    // PC wrap.
    load(32'hFFFF_FFFC);
    chk("wrap_p4_lit", id_pc_plus4, 32'h0);

    // fetch_count wrap.
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    m_cnt = 32'hFFFF_FFFF;
    load(32'h0);
    chk("cnt_wrap_lit", fetch_count, 32'h0);

    // Randomized traffic.
    pc = 32'h3000;
    for (int i = 0; i < 2000; i++) begin
      logic       r, fl;
      logic [2:0] sr;
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 9) == 0);
      sr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
      else pc = pc + 32'd4;
      step(r, pc, $urandom, sr, fl);
    end

    cnt_before = fetch_count;
    load(pc + 32'd4);
    chk("final_cnt_step", fetch_count, cnt_before + 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
# if_id_register

Fetch-to-decode pipeline register for the five-stage MIPS core. It sits directly downstream of the program counter and instruction memory, and latches the fetched word and its PC for the decode stage. It owns the freeze countdown that holds both itself and the program counter for a multi-cycle stall. It also squashes the fetched word on a taken branch or jump and counts valid instructions delivered to decode.

## Interface

Parameters:
- RESET_PC, 32'h00003000: value of id_pc after reset; matches the program counter reset vector.
- NOP_WORD, 32'h00000000: instruction word inserted for bubbles (sll $0,$0,0).
- COUNT_WIDTH, 3: width of stall_request and of the internal freeze counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- if_pc  in  32  PC of the word currently being fetched (program counter output).
- if_instr  in  32  instruction memory read data for if_pc, combinational, valid the same cycle.
- stall_request  in  COUNT_WIDTH  number of cycles to freeze fetch, from the hazard unit; 0 = no stall.
- flush  in  1  taken branch/jump resolved this cycle; squash the fetched word.
- freeze  out  COUNT_WIDTH  freeze indication to the program counter's setFreezeTime; nonzero = hold PC.
- id_valid  out  1  id_instr is a real instruction, not a bubble.
- id_pc  out  32  PC of the latched instruction.
- id_instr  out  32  latched instruction word.
- id_pc_plus4  out  32  id_pc + 4, registered.
- fetch_count  out  32  number of valid instructions latched since reset.

## Operation

- Internal state: freeze_cnt (COUNT_WIDTH bits) plus the output registers.
- hold = (freeze_cnt != 0) or (freeze_cnt == 0 and stall_request != 0).
- freeze output is combinational. It equals freeze_cnt when freeze_cnt != 0, else stall_request. It is therefore nonzero exactly when hold = 1.
- Per-edge priority: reset > flush > hold > load.
- reset: id_valid=0, id_pc=RESET_PC, id_instr=NOP_WORD, id_pc_plus4=RESET_PC+4, freeze_cnt=0, fetch_count=0.
- flush=1: id_valid=0, id_instr=NOP_WORD, id_pc=if_pc, id_pc_plus4=if_pc+4, freeze_cnt=0. Any stall_request that cycle is discarded. A pending freeze is cancelled.
- hold, with freeze_cnt==0 and stall_request=N≠0:
  - All id_* outputs keep their values.
  - freeze_cnt <= N-1.
- hold, with freeze_cnt≠0:
  - All id_* outputs keep their values.
  - freeze_cnt <= freeze_cnt-1.
  - stall_request is ignored; it is never accumulated.
- load (no flush, no hold): id_valid=1, id_pc=if_pc, id_instr=if_instr, id_pc_plus4=if_pc+4 (mod 2^32).
- fetch_count increments on every load edge. It never increments on flush, hold, or reset edges. It wraps modulo 2^32.
- Arithmetic: all PC additions are 32-bit unsigned with wrap; 32'hFFFFFFFC+4 = 0.

## Timing

- Latency: a word presented on if_pc/if_instr in cycle n appears on id_* in cycle n+1 when loaded.
- Stall of N cycles:
  - stall_request=N is sampled in cycle n.
  - The edges ending cycles n..n+N-1 are hold edges (N total).
  - freeze is nonzero during cycles n..n+N-1.
  - The first load edge ends cycle n+N.
- stall_request=1 gives exactly one hold edge and freeze_cnt stays 0.
- Flush in the last freeze cycle: flush wins and the register takes the bubble at that edge.
- Reset asserted mid-freeze clears freeze_cnt in one edge. freeze is driven by stall_request alone in the cycle after reset.
- No output is X after the first reset edge.

## Test plan

- Reset then free-run with if_pc 3000,3004,3008 -> after reset id_pc=3000_h reset value with id_valid=0. The next edges load 3000, 3004 with id_valid=1 and id_pc_plus4=3004, 3008. fetch_count increments 1, 2.
- stall_request=3 for one cycle at if_pc=3008 -> freeze nonzero for exactly 3 cycles and id_* unchanged across 3 edges. 3008 loads on the 4th edge and fetch_count rises by 1 only.
- stall_request=2 in the cycle freeze_cnt=1 -> the request is ignored and the freeze ends on schedule with no extension.
- flush with stall_request=4 in the same cycle -> id_valid=0, id_instr=0, freeze_cnt=0 and freeze=0 next cycle. fetch_count is unchanged.
- reset asserted while freeze_cnt=2 -> all outputs return to reset values next edge and freeze_cnt=0.
- if_pc=FFFFFFFC load -> id_pc_plus4=00000000. Force fetch_count=FFFFFFFF then load -> fetch_count wraps to 0.
